// File: rtl/arm_pipe_pkg.sv
// Shared pipeline types: register index, shadow-slot records and
// operand forward-select encodings.
package arm_pipe_pkg;

    localparam int REG_W = 4;
    localparam int CNT_W = 16;

    typedef logic [REG_W-1:0] reg_idx_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic     valid;
        reg_idx_t dest;
        logic     wb_en;
        logic     mem_r_en;
    } slot_t;

    typedef struct packed {
        slot_t    base;
        reg_idx_t src1;
        reg_idx_t src2;
        logic     uses_src1;
        logic     two_src;
    } exe_slot_t;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage to hazard-scoreboard bundle: decoded ID fields and pipeline
// controls in, stall/forwarding decisions and stall counter out.
interface hazard_scoreboard_if;
    import arm_pipe_pkg::*;

    logic             id_valid;
    reg_idx_t         id_src1;
    reg_idx_t         id_src2;
    logic             id_uses_src1;
    logic             id_two_src;
    reg_idx_t         id_dest;
    logic             id_wb_en;
    logic             id_mem_r_en;
    logic             freeze;
    logic             flush;
    logic             hazard;
    logic [1:0]       fwd_sel_src1;
    logic [1:0]       fwd_sel_src2;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_valid, id_src1, id_src2, id_uses_src1, id_two_src,
        output id_dest, id_wb_en, id_mem_r_en, freeze, flush,
        input  hazard, fwd_sel_src1, fwd_sel_src2, stall_cnt
    );

    modport slave (
        input  id_valid, id_src1, id_src2, id_uses_src1, id_two_src,
        input  id_dest, id_wb_en, id_mem_r_en, freeze, flush,
        output hazard, fwd_sel_src1, fwd_sel_src2, stall_cnt
    );

endinterface

// File: rtl/hazard_slot_match.sv
// RAW comparator: one shadow slot against one source register,
// gated by the source's use flag.
module hazard_slot_match
    import arm_pipe_pkg::*;
(
    input  slot_t    i_slot,
    input  reg_idx_t i_reg,
    input  logic     i_use,
    output logic     o_hit
);

    logic w_unused;

    assign o_hit = i_use & i_slot.valid & i_slot.wb_en
                 & (i_slot.dest == i_reg);
    assign w_unused = i_slot.mem_r_en;

endmodule

// File: rtl/hazard_scoreboard.sv
// EXE/MEM/WB shadow scoreboard: decides ID stalls, EXE operand
// forward selects and keeps a saturating stall-cycle counter.
module hazard_scoreboard
    import arm_pipe_pkg::*;
#(
    parameter bit FORWARD_EN = 1'b0,
    parameter bit WB_BYPASS  = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    hazard_scoreboard_if.slave  sb
);

    exe_slot_t        r_exe;
    slot_t            r_mem;
    slot_t            r_wb;
    logic [CNT_W-1:0] r_cnt;

    slot_t            w_slots [3];
    logic [2:0]       w_hit1;
    logic [2:0]       w_hit2;
    logic [2:0]       w_raw;
    logic [1:0]       w_fw1;
    logic [1:0]       w_fw2;
    logic             w_hazard;
    fwd_sel_t         w_sel1;
    fwd_sel_t         w_sel2;
    exe_slot_t        w_exe_nxt;

    assign w_slots[0] = r_exe.base;
    assign w_slots[1] = r_mem;
    assign w_slots[2] = r_wb;

    // Index 0/1/2 = EXE/MEM/WB for the ID-side compares.
    for (genvar g = 0; g < 3; g++) begin : g_id
        hazard_slot_match u_s1 (
            .i_slot (w_slots[g]),
            .i_reg  (sb.id_src1),
            .i_use  (sb.id_uses_src1),
            .o_hit  (w_hit1[g])
        );
        hazard_slot_match u_s2 (
            .i_slot (w_slots[g]),
            .i_reg  (sb.id_src2),
            .i_use  (sb.id_two_src),
            .o_hit  (w_hit2[g])
        );
    end

    // Index 0/1 = MEM/WB producers for the EXE-side operands.
    for (genvar g = 0; g < 2; g++) begin : g_fwd
        hazard_slot_match u_f1 (
            .i_slot (w_slots[g+1]),
            .i_reg  (r_exe.src1),
            .i_use  (r_exe.uses_src1),
            .o_hit  (w_fw1[g])
        );
        hazard_slot_match u_f2 (
            .i_slot (w_slots[g+1]),
            .i_reg  (r_exe.src2),
            .i_use  (r_exe.two_src),
            .o_hit  (w_fw2[g])
        );
    end

    assign w_raw = w_hit1 | w_hit2;

    always_comb begin
        w_hazard = 1'b0;
        if (FORWARD_EN) begin
            w_hazard = sb.id_valid & w_raw[0] & r_exe.base.mem_r_en;
        end else begin
            w_hazard = sb.id_valid
                     & (w_raw[0] | w_raw[1] | (!WB_BYPASS & w_raw[2]));
        end
    end

    // Both producers may match; the younger MEM result wins.
    always_comb begin
        w_sel1 = FWD_RF;
        w_sel2 = FWD_RF;
        if (FORWARD_EN) begin
            priority case (1'b1)
                w_fw1[0]: w_sel1 = FWD_MEM;
                w_fw1[1]: w_sel1 = FWD_WB;
                default:  w_sel1 = FWD_RF;
            endcase
            priority case (1'b1)
                w_fw2[0]: w_sel2 = FWD_MEM;
                w_fw2[1]: w_sel2 = FWD_WB;
                default:  w_sel2 = FWD_RF;
            endcase
        end
    end

    always_comb begin
        w_exe_nxt = '0;
        if (sb.id_valid && !w_hazard && !sb.flush) begin
            w_exe_nxt.base.valid    = 1'b1;
            w_exe_nxt.base.dest     = sb.id_dest;
            w_exe_nxt.base.wb_en    = sb.id_wb_en;
            w_exe_nxt.base.mem_r_en = sb.id_mem_r_en;
            w_exe_nxt.src1          = sb.id_src1;
            w_exe_nxt.src2          = sb.id_src2;
            w_exe_nxt.uses_src1     = sb.id_uses_src1;
            w_exe_nxt.two_src       = sb.id_two_src;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_exe <= '0;
            r_mem <= '0;
            r_wb  <= '0;
            r_cnt <= '0;
        end else if (!sb.freeze) begin
            r_wb  <= r_mem;
            r_mem <= r_exe.base;
            r_exe <= w_exe_nxt;
            if (w_hazard && (r_cnt != '1)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign sb.hazard       = w_hazard;
    assign sb.fwd_sel_src1 = w_sel1;
    assign sb.fwd_sel_src2 = w_sel2;
    assign sb.stall_cnt    = r_cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench: three scoreboards (no-forward, forward, no-WB-bypass) driven
// with the same ID stream; expected outputs pass through a queue.
module tb_hazard_scoreboard;
    import arm_pipe_pkg::*;

    typedef struct packed {
        logic       v;
        logic [3:0] d;
        logic       wb;
        logic       ld;
        logic [3:0] a;
        logic       ua;
        logic [3:0] b;
        logic       ub;
        logic       frz;
        logic       fl;
    } stim_t;

    // hz = {dut2, dut1, dut0}; s1/s2 = forwarding DUT selects
    typedef struct packed {
        logic [2:0] hz;
        logic [1:0] s1;
        logic [1:0] s2;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [3:0] id_src1, id_src2, id_dest;
    logic       id_uses_src1, id_two_src, id_wb_en, id_mem_r_en;
    logic       freeze, flush;

    logic        hz [3];
    logic [1:0]  s1 [3];
    logic [1:0]  s2 [3];
    logic [15:0] sc [3];

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        hazard_scoreboard_if u_if ();
        assign u_if.id_valid     = id_valid;
        assign u_if.id_src1      = id_src1;
        assign u_if.id_src2      = id_src2;
        assign u_if.id_uses_src1 = id_uses_src1;
        assign u_if.id_two_src   = id_two_src;
        assign u_if.id_dest      = id_dest;
        assign u_if.id_wb_en     = id_wb_en;
        assign u_if.id_mem_r_en  = id_mem_r_en;
        assign u_if.freeze       = freeze;
        assign u_if.flush        = flush;
        assign hz[g] = u_if.hazard;
        assign s1[g] = u_if.fwd_sel_src1;
        assign s2[g] = u_if.fwd_sel_src2;
        assign sc[g] = u_if.stall_cnt;
        hazard_scoreboard #(
            .FORWARD_EN (g == 1),
            .WB_BYPASS  (g != 2)
        ) u_dut (
            .clk (clk),
            .rst (rst),
            .sb  (u_if)
        );
    end

    function automatic stim_t op(input logic [3:0] d, input logic wb,
                                 input logic ld, input logic [3:0] a,
                                 input logic ua, input logic [3:0] b,
                                 input logic ub);
        stim_t s;
        s = '0;
        s.v = 1'b1; s.d = d; s.wb = wb; s.ld = ld;
        s.a = a; s.ua = ua; s.b = b; s.ub = ub;
        return s;
    endfunction

    task automatic drv(input stim_t s);
        id_valid = s.v;   id_dest = s.d;  id_wb_en = s.wb;
        id_mem_r_en = s.ld;
        id_src1 = s.a;    id_uses_src1 = s.ua;
        id_src2 = s.b;    id_two_src = s.ub;
        freeze = s.frz;   flush = s.fl;
    endtask

    task automatic do_reset;
        drv('0);
        rst = 1'b0;
        #2;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        drv(op(4'd5, 1'b1, 1'b0, 4'd5, 1'b1, 4'd5, 1'b1));
        rst = 1'b0;
        #1;
        for (int g = 0; g < 3; g++) begin
            n_tests++;
            if ({hz[g], s1[g], s2[g], sc[g]} !== 21'd0) begin
                n_fail++;
                $display("FAIL reset dut%0d got hz=%b s1=%b s2=%b cnt=%0d want all 0",
                         g, hz[g], s1[g], s2[g], sc[g]);
            end
        end
    endtask

    task automatic test_raw_stall;
        stim_t st[5];
        exp_t  ex[5];
        exp_t  e;
        stim_t add1, sub1;
        add1 = op(4'd1, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        sub1 = op(4'd4, 1'b1, 1'b0, 4'd1, 1'b1, 4'd0, 1'b0);
        st[0] = add1; ex[0] = {3'b000, 2'b00, 2'b00};
        st[1] = sub1; ex[1] = {3'b101, 2'b00, 2'b00};
        st[2] = sub1; ex[2] = {3'b101, 2'b01, 2'b00};
        st[3] = sub1; ex[3] = {3'b100, 2'b10, 2'b00};
        st[4] = sub1; ex[4] = {3'b000, 2'b00, 2'b00};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drv(st[i]);
            q.push_back(ex[i]);
            #1;
            e = q.pop_front();
            n_tests++;
            if ({hz[2], hz[1], hz[0]} !== e.hz) begin
                n_fail++;
                $display("FAIL raw_stall[%0d] hazard got %b want %b",
                         i, {hz[2], hz[1], hz[0]}, e.hz);
            end
            n_tests++;
            if ({s1[1], s2[1]} !== {e.s1, e.s2}) begin
                n_fail++;
                $display("FAIL raw_stall[%0d] fwd got %b want %b",
                         i, {s1[1], s2[1]}, {e.s1, e.s2});
            end
            n_tests++;
            if ({s1[0], s2[0], s1[2], s2[2]} !== 8'h00) begin
                n_fail++;
                $display("FAIL raw_stall[%0d] fwd_off got %b want 0",
                         i, {s1[0], s2[0], s1[2], s2[2]});
            end
            @(posedge clk);
            #1;
        end
        n_tests++;
        if ({sc[0], sc[1], sc[2]} !== {16'd2, 16'd0, 16'd3}) begin
            n_fail++;
            $display("FAIL raw_stall cnt got %0d/%0d/%0d want 2/0/3",
                     sc[0], sc[1], sc[2]);
        end
    endtask

    task automatic test_load_use;
        stim_t st[4];
        exp_t  ex[4];
        exp_t  e;
        stim_t ldr2, add2;
        ldr2 = op(4'd2, 1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
        add2 = op(4'd5, 1'b1, 1'b0, 4'd7, 1'b1, 4'd2, 1'b1);
        st[0] = ldr2; ex[0] = {3'b000, 2'b00, 2'b00};
        st[1] = add2; ex[1] = {3'b111, 2'b00, 2'b00};
        st[2] = add2; ex[2] = {3'b101, 2'b00, 2'b00};
        st[3] = '0;   ex[3] = {3'b000, 2'b00, 2'b10};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drv(st[i]);
            q.push_back(ex[i]);
            #1;
            e = q.pop_front();
            n_tests++;
            if ({hz[2], hz[1], hz[0]} !== e.hz) begin
                n_fail++;
                $display("FAIL load_use[%0d] hazard got %b want %b",
                         i, {hz[2], hz[1], hz[0]}, e.hz);
            end
            n_tests++;
            if ({s1[1], s2[1]} !== {e.s1, e.s2}) begin
                n_fail++;
                $display("FAIL load_use[%0d] fwd got %b want %b",
                         i, {s1[1], s2[1]}, {e.s1, e.s2});
            end
            @(posedge clk);
            #1;
        end
        n_tests++;
        if ({sc[0], sc[1], sc[2]} !== {16'd2, 16'd1, 16'd2}) begin
            n_fail++;
            $display("FAIL load_use cnt got %0d/%0d/%0d want 2/1/2",
                     sc[0], sc[1], sc[2]);
        end
    endtask

    task automatic test_fwd_priority;
        stim_t st[4];
        exp_t  ex[4];
        exp_t  e;
        stim_t p3, c3;
        p3 = op(4'd3, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        c3 = op(4'd6, 1'b1, 1'b0, 4'd3, 1'b1, 4'd0, 1'b0);
        st[0] = p3; ex[0] = {3'b000, 2'b00, 2'b00};
        st[1] = p3; ex[1] = {3'b000, 2'b00, 2'b00};
        st[2] = c3; ex[2] = {3'b101, 2'b00, 2'b00};
        st[3] = '0; ex[3] = {3'b000, 2'b01, 2'b00};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drv(st[i]);
            q.push_back(ex[i]);
            #1;
            e = q.pop_front();
            n_tests++;
            if ({hz[2], hz[1], hz[0]} !== e.hz) begin
                n_fail++;
                $display("FAIL fwd_prio[%0d] hazard got %b want %b",
                         i, {hz[2], hz[1], hz[0]}, e.hz);
            end
            n_tests++;
            if ({s1[1], s2[1]} !== {e.s1, e.s2}) begin
                n_fail++;
                $display("FAIL fwd_prio[%0d] fwd got %b want %b",
                         i, {s1[1], s2[1]}, {e.s1, e.s2});
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_freeze;
        stim_t st[8];
        exp_t  ex[8];
        exp_t  e;
        stim_t add1, sub1, subf;
        add1 = op(4'd1, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        sub1 = op(4'd4, 1'b1, 1'b0, 4'd1, 1'b1, 4'd0, 1'b0);
        subf = sub1;
        subf.frz = 1'b1;
        st[0] = add1; ex[0] = {3'b000, 2'b00, 2'b00};
        st[1] = subf; ex[1] = {3'b101, 2'b00, 2'b00};
        st[2] = subf; ex[2] = {3'b101, 2'b00, 2'b00};
        st[3] = subf; ex[3] = {3'b101, 2'b00, 2'b00};
        st[4] = sub1; ex[4] = {3'b101, 2'b00, 2'b00};
        st[5] = sub1; ex[5] = {3'b101, 2'b01, 2'b00};
        st[6] = sub1; ex[6] = {3'b100, 2'b10, 2'b00};
        st[7] = sub1; ex[7] = {3'b000, 2'b00, 2'b00};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drv(st[i]);
            q.push_back(ex[i]);
            #1;
            e = q.pop_front();
            n_tests++;
            if ({hz[2], hz[1], hz[0]} !== e.hz) begin
                n_fail++;
                $display("FAIL freeze[%0d] hazard got %b want %b",
                         i, {hz[2], hz[1], hz[0]}, e.hz);
            end
            n_tests++;
            if ({s1[1], s2[1]} !== {e.s1, e.s2}) begin
                n_fail++;
                $display("FAIL freeze[%0d] fwd got %b want %b",
                         i, {s1[1], s2[1]}, {e.s1, e.s2});
            end
            if (i >= 1 && i <= 4) begin
                n_tests++;
                if ({sc[0], sc[2]} !== 32'd0) begin
                    n_fail++;
                    $display("FAIL freeze[%0d] cnt got %0d/%0d want 0/0",
                             i, sc[0], sc[2]);
                end
            end
            @(posedge clk);
            #1;
        end
        n_tests++;
        if ({sc[0], sc[1], sc[2]} !== {16'd2, 16'd0, 16'd3}) begin
            n_fail++;
            $display("FAIL freeze cnt got %0d/%0d/%0d want 2/0/3",
                     sc[0], sc[1], sc[2]);
        end
    endtask

    task automatic test_flush;
        stim_t st[5];
        exp_t  ex[5];
        exp_t  e;
        stim_t add1, sub1;
        add1 = op(4'd1, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        sub1 = op(4'd4, 1'b1, 1'b0, 4'd1, 1'b1, 4'd0, 1'b0);
        st[0] = add1; st[0].fl = 1'b1; ex[0] = {3'b000, 2'b00, 2'b00};
        st[1] = sub1;                  ex[1] = {3'b000, 2'b00, 2'b00};
        st[2] = add1;                  ex[2] = {3'b000, 2'b00, 2'b00};
        st[3] = sub1; st[3].fl = 1'b1; ex[3] = {3'b101, 2'b00, 2'b00};
        st[4] = sub1;                  ex[4] = {3'b101, 2'b00, 2'b00};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drv(st[i]);
            q.push_back(ex[i]);
            #1;
            e = q.pop_front();
            n_tests++;
            if ({hz[2], hz[1], hz[0]} !== e.hz) begin
                n_fail++;
                $display("FAIL flush[%0d] hazard got %b want %b",
                         i, {hz[2], hz[1], hz[0]}, e.hz);
            end
            n_tests++;
            if ({s1[1], s2[1]} !== {e.s1, e.s2}) begin
                n_fail++;
                $display("FAIL flush[%0d] fwd got %b want %b",
                         i, {s1[1], s2[1]}, {e.s1, e.s2});
            end
            @(posedge clk);
            #1;
        end
        n_tests++;
        if ({sc[0], sc[1], sc[2]} !== {16'd2, 16'd0, 16'd2}) begin
            n_fail++;
            $display("FAIL flush cnt got %0d/%0d/%0d want 2/0/2",
                     sc[0], sc[1], sc[2]);
        end
    endtask

    // Continues from test_flush: ADD R1 is still in WB, SUB R1 in ID.
    task automatic test_reset_mid;
        n_tests++;
        if ({hz[2], hz[1], hz[0]} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_mid pre hazard got %b want 100",
                     {hz[2], hz[1], hz[0]});
        end
        rst = 1'b0;
        #1;
        for (int g = 0; g < 3; g++) begin
            n_tests++;
            if ({hz[g], s1[g], s2[g], sc[g]} !== 21'd0) begin
                n_fail++;
                $display("FAIL reset_mid dut%0d got hz=%b s1=%b s2=%b cnt=%0d want all 0",
                         g, hz[g], s1[g], s2[g], sc[g]);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_tests++;
        if ({hz[2], hz[1], hz[0], sc[0], sc[2]} !== 35'd0) begin
            n_fail++;
            $display("FAIL reset_mid post got hz=%b cnt=%0d/%0d want 000 0/0",
                     {hz[2], hz[1], hz[0]}, sc[0], sc[2]);
        end
    endtask

    // Self-dependent pair: dut2 stalls 3 of every 4 cycles, dut0 2 of 4.
    task automatic test_saturate;
        stim_t p1, r1;
        p1 = op(4'd1, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        r1 = op(4'd0, 1'b0, 1'b0, 4'd1, 1'b1, 4'd0, 1'b0);
        do_reset();
        for (int i = 0; i < 21847; i++) begin
            drv(p1);
            @(posedge clk);
            #1;
            repeat (3) begin
                drv(r1);
                @(posedge clk);
                #1;
            end
            if (i == 21844) begin
                n_tests++;
                if ({sc[0], sc[2]} !== {16'd43690, 16'hFFFF}) begin
                    n_fail++;
                    $display("FAIL sat_edge cnt got %0d/%h want 43690/ffff",
                             sc[0], sc[2]);
                end
            end
        end
        n_tests++;
        if ({sc[0], sc[1], sc[2]} !== {16'd43694, 16'd0, 16'hFFFF}) begin
            n_fail++;
            $display("FAIL saturate cnt got %0d/%0d/%h want 43694/0/ffff",
                     sc[0], sc[1], sc[2]);
        end
    endtask

    initial begin
        test_reset();
        test_raw_stall();
        test_load_use();
        test_fwd_priority();
        test_freeze();
        test_flush();
        test_reset_mid();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
